// File: rtl/ctl_enemy_fire_sched_pkg.sv
// Shared definitions for the enemy fire scheduler: FSM state encodings,
// position width, enemy table limit, LFSR seed/taps and a divider-free
// modulo helper used when the randomised start pointer is built in.
package ctl_enemy_fire_sched_pkg;

    localparam int          POS_W     = 11;
    localparam int          MAX_EN    = 16;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 -> bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COOL  = 3'd1,
        ST_SCAN  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_HOLD  = 3'd4
    } fire_state_e;

    // Remainder of v / n using a restoring compare/subtract ladder (no divider)
    function automatic logic [15:0] mod_by_n(input logic [15:0] v, input int unsigned n);
        logic [31:0] rem;
        rem = {16'd0, v};
        for (int k = 15; k >= 0; k--) begin
            if (rem >= (32'(n) << k)) rem = rem - (32'(n) << k);
        end
        return rem[15:0];
    endfunction

endpackage

// File: rtl/ctl_enemy_fire_sched_lfsr_16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded at reset, steps when en=1.
// Only compiled in when ENEMY_FIRE_RANDOM_EN is defined, so the default build
// carries no LFSR flops at all.
`ifdef ENEMY_FIRE_RANDOM_EN
module lfsr_16
    import ctl_enemy_fire_sched_pkg::*;
(
    input  logic        pclk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] q
);

    // Shift left, feedback parity of the tapped bits enters at bit 0
    always_ff @(posedge pclk) begin
        if (!rst) begin
            q <= LFSR_SEED;
        end else if (en) begin
            q <= {q[14:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule
`endif

// File: rtl/ctl_enemy_fire_sched.sv
// Enemy fire scheduler: round-robin scan of the enemy table gated by a
// cooldown timer; issues a 1-cycle fire pulse to the lowest free missile slot
// and holds that slot's launch x/y until the slot is fired again.
// Optional feature macro: ENEMY_FIRE_RANDOM_EN (LFSR-randomised scan start).
//
// Handshake: fire[s] is a single-cycle strobe, only ever raised while
// slot_busy[s]==0 in that same cycle; the slot accepts it unconditionally and
// samples slot_xpos/slot_ypos one cycle later, which HOLD keeps stable.
module ctl_enemy_fire_sched
    import ctl_enemy_fire_sched_pkg::*;
#(
    parameter int N_EN        = 8,
    parameter int N_SLOT      = 2,
    parameter int FIRE_PERIOD = 90000,
    parameter int X_OFFSET    = 24,
    parameter int Y_OFFSET    = 64
) (
    input  logic                    pclk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [N_EN-1:0]         enemy_alive,
    input  logic [POS_W*N_EN-1:0]   enemy_xpos,
    input  logic [POS_W*N_EN-1:0]   enemy_ypos,
    input  logic [N_SLOT-1:0]       slot_busy,
    output logic [N_SLOT-1:0]       fire,
    output logic [POS_W*N_SLOT-1:0] slot_xpos,
    output logic [POS_W*N_SLOT-1:0] slot_ypos,
    output logic [3:0]              last_id,
    output fire_state_e             state_dbg
);

    localparam int PW = (N_EN > 1) ? $clog2(N_EN) : 1;
    localparam int CW = $clog2(FIRE_PERIOD + 1);
    localparam int IW = $clog2(MAX_EN);
    localparam logic [CW-1:0]    COOL_MAX = CW'(FIRE_PERIOD);
    localparam logic [PW-1:0]    LAST_EN  = PW'(N_EN - 1);
    localparam logic [POS_W-1:0] X_ADD    = POS_W'(X_OFFSET);
    localparam logic [POS_W-1:0] Y_ADD    = POS_W'(Y_OFFSET);

    fire_state_e      state_q, state_d;
    logic [CW-1:0]    cool_q, cool_d, cool_inc;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    cand_q, cand_d;
    logic [PW-1:0]    dead_q, dead_d;
    logic             hold_q, hold_d;
    logic [IW-1:0]    last_q, last_d;
    logic [N_SLOT-1:0] free_oh;
    logic [POS_W-1:0] slot_x_q [N_SLOT];
    logic [POS_W-1:0] slot_x_d [N_SLOT];
    logic [POS_W-1:0] slot_y_q [N_SLOT];
    logic [POS_W-1:0] slot_y_d [N_SLOT];
    logic [POS_W-1:0] en_x [N_EN];
    logic [POS_W-1:0] en_y [N_EN];

`ifdef ENEMY_FIRE_RANDOM_EN
    logic [15:0] lfsr_q;

    lfsr_16 u_lfsr (
        .pclk (pclk),
        .rst  (rst),
        .en   (1'b1),
        .q    (lfsr_q)
    );
`endif

    // Fixed-priority find-first-zero: one-hot of the lowest free slot, or 0
    function automatic logic [N_SLOT-1:0] first_free(input logic [N_SLOT-1:0] busy);
        logic [N_SLOT-1:0] oh;
        oh = '0;
        for (int s = N_SLOT - 1; s >= 0; s--) begin
            if (!busy[s]) begin
                oh    = '0;
                oh[s] = 1'b1;
            end
        end
        return oh;
    endfunction

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST_EN) ? '0 : p + 1'b1;
    endfunction

    for (genvar i = 0; i < N_EN; i++) begin : g_en
        assign en_x[i] = enemy_xpos[POS_W*i +: POS_W];
        assign en_y[i] = enemy_ypos[POS_W*i +: POS_W];
    end

    for (genvar s = 0; s < N_SLOT; s++) begin : g_slot
        assign slot_xpos[POS_W*s +: POS_W] = slot_x_q[s];
        assign slot_ypos[POS_W*s +: POS_W] = slot_y_q[s];
    end

    assign last_id   = 4'(last_q);
    assign state_dbg = state_q;

    // Next-state, datapath updates and the fire strobe
    always_comb begin
        state_d  = state_q;
        cool_d   = cool_q;
        ptr_d    = ptr_q;
        cand_d   = cand_q;
        dead_d   = dead_q;
        hold_d   = hold_q;
        last_d   = last_q;
        slot_x_d = slot_x_q;
        slot_y_d = slot_y_q;
        fire     = '0;
        free_oh  = first_free(slot_busy);
        cool_inc = (cool_q == COOL_MAX) ? COOL_MAX : cool_q + 1'b1;

        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_COOL;
                    cool_d  = '0;
                end
                ST_COOL: begin
                    // Saturates; with every slot busy we wait here without losing the shot
                    cool_d = cool_inc;
                    if (cool_inc == COOL_MAX && !(&slot_busy)) begin
                        state_d = ST_SCAN;
                        dead_d  = '0;
`ifdef ENEMY_FIRE_RANDOM_EN
                        ptr_d   = PW'(mod_by_n(lfsr_q, N_EN));
`else
                        ptr_d   = ptr_q;
`endif
                    end
                end
                ST_SCAN: begin
                    if (enemy_alive[ptr_q]) begin
                        cand_d  = ptr_q;
                        state_d = ST_ISSUE;
                    end else begin
                        ptr_d = ptr_next(ptr_q);
                        if (dead_q == LAST_EN) begin
                            state_d = ST_COOL;
                            cool_d  = '0;
                        end else begin
                            dead_d = dead_q + 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    // Slot choice uses live busy bits so a slot taken since SCAN is skipped
                    if (|free_oh) begin
                        fire = free_oh;
                        for (int s = 0; s < N_SLOT; s++) begin
                            if (free_oh[s]) begin
                                slot_x_d[s] = en_x[cand_q] + X_ADD;
                                slot_y_d[s] = en_y[cand_q] + Y_ADD;
                            end
                        end
                        last_d  = IW'(cand_q);
                        ptr_d   = ptr_next(cand_q);
                        hold_d  = 1'b0;
                        state_d = ST_HOLD;
                    end else begin
                        // Cooldown is still saturated, so COOL retries as soon as a slot frees
                        state_d = ST_COOL;
                    end
                end
                ST_HOLD: begin
                    if (hold_q) begin
                        state_d = ST_COOL;
                        cool_d  = '0;
                    end else begin
                        hold_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge pclk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cool_q  <= '0;
            ptr_q   <= '0;
            cand_q  <= '0;
            dead_q  <= '0;
            hold_q  <= 1'b0;
            last_q  <= '0;
            for (int s = 0; s < N_SLOT; s++) begin
                slot_x_q[s] <= '0;
                slot_y_q[s] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cool_q   <= cool_d;
            ptr_q    <= ptr_d;
            cand_q   <= cand_d;
            dead_q   <= dead_d;
            hold_q   <= hold_d;
            last_q   <= last_d;
            slot_x_q <= slot_x_d;
            slot_y_q <= slot_y_d;
        end
    end

endmodule
